mux_2to1: RTL and testbench
===========================

# mux_2to1

Datapath 2:1 selector feeding the ALU B-operand in the pipeline's execute stage. `select` (ALUSrc) chooses between the register operand (`input0`) and the immediate (`input1`). The selected value is available combinationally on `out`, which the ALU consumes in the same cycle, and as a one-cycle registered copy on `out_q`. Optional saturating usage counters support debug and performance inspection.

## Interface
- `WIDTH`, default 32: data width of `input0`, `input1`, `out` and `out_q`.
- `CNT_W`, default 16: width of the statistics counters.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `input0` input WIDTH: register operand, selected when `select`=0.
- `input1` input WIDTH: immediate operand, selected when `select`=1.
- `select` input 1: ALUSrc.
- `out` output WIDTH: combinational selection.
- `out_q` output WIDTH: `out` registered one cycle.
- `same_q` output 1: registered flag, set when `input0`==`input1`.
- `sel1_cnt` output CNT_W: number of cycles with `select`=1. Present only with STATS enabled.
- `toggle_cnt` output CNT_W: number of `select` transitions. Present only with STATS enabled.

## Operation
- `out = select ? input1 : input0`, bit-for-bit with no transformation.
  - Purely combinational.
  - Independent of `clk` and `reset`, so `out` is valid during reset.
- If `select` is X or Z in simulation, `out` is driven to all X. Synthesis ignores this case.
- Each rising edge:
  - `out_q <= out`.
  - `same_q <= (input0 == input1)`.
- Statistics (when enabled):
  - `sel1_cnt` increments when `select`=1.
  - `toggle_cnt` increments when `select` differs from its previous-cycle sampled value (internal `sel_prev`).
  - Both counters saturate at all-ones and never wrap.
- Reset (when `reset`=1 at a rising edge):
  - `out_q`=0, `same_q`=0, `sel_prev`=0, both counters=0.
  - Reset has priority over the normal update in the same cycle.
- First cycle after reset: a toggle is counted only if `select`=1, because `sel_prev` resets to 0.

## Timing
- `out` has zero latency. It settles within one combinational mux delay of any change on the inputs or `select`.
- `out_q` and `same_q` have 1-cycle latency.
- Counters reflect a cycle's `select` on the following edge.
- Reset asserted mid-operation clears all registered outputs at the next edge. `out` is unaffected.
- There is no handshake. Inputs are sampled every cycle.

## Configuration
- Macro: `MUX2TO1_STATS_EN`.
- Defined:
  - `sel_prev`, `sel1_cnt` and `toggle_cnt` exist.
  - The counter ports are present and behave as described in Operation.
- Undefined:
  - The counter ports and all counter logic are omitted.
  - `out`, `out_q` and `same_q` behave identically to the defined case.

## Structure
- Package `mux2to1_pkg`:
  - `DATA_W_DEF` = 32, `CNT_W_DEF` = 16.
  - Typedef `data_t` (logic [DATA_W_DEF-1:0]).
  - Typedef `cnt_t` (logic [CNT_W_DEF-1:0]).
- Sub-module `sat_counter`:
  - Ports: `clk`, `reset`, `inc`, `count`.
  - Parameterized width; saturates at all-ones.
  - Instantiated twice under `MUX2TO1_STATS_EN`.

## Test plan
- Mux, `select`=0: `input0`=0x000000A5, `input1`=0x12345678, `select`=0 -> `out`=0x000000A5 immediately.
- Mux, `select`=1: same inputs, `select`=1 -> `out`=0x12345678.
- Mux, new inputs: `input0`=0xDEADBEEF, `input1`=0x00000010.
  - `select`=0 -> `out`=0xDEADBEEF.
  - `select`=1 -> `out`=0x00000010.
  - `out_q` follows `out` one edge later.
- Equal inputs: both inputs 0xCAFEBABE, `select` 0 then 1.
  - `out`=0xCAFEBABE in both cases.
  - `same_q`=1 after the next edge.
- Reset and statistics: `reset`=1 for one edge -> `out_q`=0, `same_q`=0, counters=0, while `out` still tracks its inputs.
  - With STATS enabled, then drive `select` 1,0,1,1 -> `sel1_cnt`=3, `toggle_cnt`=3.
- Saturation: with `CNT_W`=4, hold `select`=1 for 20 cycles -> `sel1_cnt` stops at 15 and never wraps.

Source files
------------

// File: rtl/mux_2to1_pkg.sv
// mux2to1_pkg: shared defaults and types for the execute-stage B-operand
// selector (mux_2to1) and its statistics counters.
//   DATA_W_DEF - default operand width
//   CNT_W_DEF  - default statistics counter width
//   data_t     - operand type at the default width
//   cnt_t      - counter type at the default width
package mux2to1_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [CNT_W_DEF-1:0]  cnt_t;

endpackage

// File: rtl/mux_2to1_if.sv
// mux_2to1_if: operand/result bundle for mux_2to1.
//   input0, input1 - register operand / immediate operand (WIDTH)
//   select         - ALUSrc (1 picks input1)
//   out            - combinational selection (WIDTH)
//   out_q          - out registered one cycle (WIDTH)
//   same_q         - registered input0 == input1 flag
//   sel1_cnt       - cycles with select=1 (CNT_W, only with MUX2TO1_STATS_EN)
//   toggle_cnt     - select transitions (CNT_W, only with MUX2TO1_STATS_EN)
// Modports: master drives operands and select, slave (the mux) drives results.
interface mux_2to1_if
  import mux2to1_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic [WIDTH-1:0] input0;
  logic [WIDTH-1:0] input1;
  logic             select;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             same_q;
`ifdef MUX2TO1_STATS_EN
  logic [CNT_W-1:0] sel1_cnt;
  logic [CNT_W-1:0] toggle_cnt;
`endif

  modport master (
    output input0, input1, select,
    input  out, out_q, same_q
`ifdef MUX2TO1_STATS_EN
    , input sel1_cnt, toggle_cnt
`endif
  );

  modport slave (
    input  input0, input1, select,
    output out, out_q, same_q
`ifdef MUX2TO1_STATS_EN
    , output sel1_cnt, toggle_cnt
`endif
  );

endinterface

// File: rtl/mux_2to1_sat_counter.sv
// sat_counter: synchronous up-counter that sticks at all-ones.
//   clk   - clock, counts on the rising edge
//   reset - synchronous active-high clear
//   inc   - count enable for this cycle
//   count - current value (WIDTH bits), never wraps
module sat_counter
  import mux2to1_pkg::*;
#(
  parameter int WIDTH = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);

  // Count register: clear on reset, otherwise increment until all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= CNT_ZERO;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mux_2to1.sv
// mux_2to1: ALU B-operand selector for the execute stage.
//   clk   - single clock
//   reset - synchronous active-high reset
//   bus   - mux_2to1_if.slave (operands, select, out, out_q, same_q,
//           and the usage counters when MUX2TO1_STATS_EN is defined)
// out is purely combinational and stays valid through reset; out_q and
// same_q are one-cycle registered copies. Defining MUX2TO1_STATS_EN adds
// saturating select=1 and select-toggle counters.
module mux_2to1
  import mux2to1_pkg::*;
#(
  parameter int WIDTH = DATA_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  mux_2to1_if.slave  bus
);

  logic [WIDTH-1:0] out_s;

  // Operand selection; an unknown select poisons the whole result in
  // simulation instead of merging the two operands bitwise.
  always_comb begin
    out_s = {WIDTH{1'b0}};
    case (bus.select)
      1'b0:    out_s = bus.input0;
      1'b1:    out_s = bus.input1;
      default: out_s = {WIDTH{1'bx}};
    endcase
  end

  assign bus.out = out_s;

  // Registered copy of the selection and the operand-equality flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_q  <= {WIDTH{1'b0}};
      bus.same_q <= 1'b0;
    end else begin
      bus.out_q  <= out_s;
      bus.same_q <= (bus.input0 == bus.input1);
    end
  end

`ifdef MUX2TO1_STATS_EN
  logic sel_prev;
  logic toggle_s;

  // Previous-cycle select; resetting to 0 means a select=1 in the first
  // cycle after reset counts as a toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_prev <= 1'b0;
    end else begin
      sel_prev <= bus.select;
    end
  end

  assign toggle_s = (bus.select != sel_prev);

  sat_counter #(.WIDTH(CNT_W)) u_sel1_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.select),
    .count (bus.sel1_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_toggle_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (toggle_s),
    .count (bus.toggle_cnt)
  );
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// tb_mux_2to1: directed plus randomized bench for mux_2to1 against a
// behavioural reference model; also exercises a 4-bit sat_counter directly
// so saturation is observable in every build.
module tb_mux_2to1;

  localparam int W    = 32;
  localparam int CW   = 16;
  localparam int SATW = 4;

  logic clk;
  logic reset;
  logic sat_inc;
  logic [SATW-1:0] sat_count;

  int vectors;
  int miscompares;

  // reference model state
  logic [W-1:0] exp_q;
  logic         exp_same;
  int           exp_sel1;
  int           exp_tog;
  logic         exp_prev;
  int           exp_sat;

  mux_2to1_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  mux_2to1 #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  sat_counter #(.WIDTH(SATW)) u_sat (
    .clk   (clk),
    .reset (reset),
    .inc   (sat_inc),
    .count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check out combinationally, advance the model,
  // then check registered outputs just after the rising edge.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic r, input logic si);
    int cmax;
    int smax;
    cmax = (1 << CW) - 1;
    smax = (1 << SATW) - 1;
    bus.input0 = a;
    bus.input1 = b;
    bus.select = s;
    reset      = r;
    sat_inc    = si;
    #1;
    chk("out", 64'(bus.out), 64'(s ? b : a));
    if (r) begin
      exp_q    = '0;
      exp_same = 1'b0;
      exp_sel1 = 0;
      exp_tog  = 0;
      exp_prev = 1'b0;
      exp_sat  = 0;
    end else begin
      exp_q    = s ? b : a;
      exp_same = (a == b);
      if (s && exp_sel1 < cmax) exp_sel1++;
      if ((s != exp_prev) && exp_tog < cmax) exp_tog++;
      exp_prev = s;
      if (si && exp_sat < smax) exp_sat++;
    end
    @(posedge clk);
    #1;
    chk("out_q", 64'(bus.out_q), 64'(exp_q));
    chk("same_q", 64'(bus.same_q), 64'(exp_same));
    chk("sat_count", 64'(sat_count), 64'(exp_sat));
`ifdef MUX2TO1_STATS_EN
    chk("sel1_cnt", 64'(bus.sel1_cnt), 64'(exp_sel1));
    chk("toggle_cnt", 64'(bus.toggle_cnt), 64'(exp_tog));
`endif
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    vectors     = 0;
    miscompares = 0;
    exp_q = '0; exp_same = 1'b0; exp_sel1 = 0; exp_tog = 0; exp_prev = 1'b0; exp_sat = 0;
    bus.input0 = '0; bus.input1 = '0; bus.select = 1'b0; reset = 1'b1; sat_inc = 1'b0;

    @(negedge clk);
    step(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    step(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b1, 1'b0);

    // directed mux cases
    step(32'h0000_00A5, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    step(32'h0000_00A5, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    step(32'hDEAD_BEEF, 32'h0000_0010, 1'b0, 1'b0, 1'b0);
    step(32'hDEAD_BEEF, 32'h0000_0010, 1'b1, 1'b0, 1'b0);
    step(32'hCAFE_BABE, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b0);
    chk("same_q_eq0", 64'(bus.same_q), 64'(1'b1));
    step(32'hCAFE_BABE, 32'hCAFE_BABE, 1'b1, 1'b0, 1'b0);
    chk("same_q_eq1", 64'(bus.same_q), 64'(1'b1));

    // reset mid-operation, out keeps tracking
    step(32'h1111_2222, 32'h3333_4444, 1'b1, 1'b1, 1'b1);
    chk("out_q_rst", 64'(bus.out_q), 64'(0));

    // select pattern 1,0,1,1 after reset
    step(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    step(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    step(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
    step(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
`ifdef MUX2TO1_STATS_EN
    chk("sel1_pattern", 64'(bus.sel1_cnt), 64'(3));
    chk("toggle_pattern", 64'(bus.toggle_cnt), 64'(3));
`endif

    // randomized traffic with occasional reset and equal operands
    for (int i = 0; i < 300; i++) begin
      ra = $urandom();
      rb = ($urandom_range(0, 7) == 0) ? ra : $urandom();
      step(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 24) == 0),
           1'($urandom_range(0, 1)));
    end

    // saturation: hold select and counter enable high for 20 cycles
    step(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step($urandom(), $urandom(), 1'b1, 1'b0, 1'b1);
    end
    chk("sat_stop", 64'(sat_count), 64'(15));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
